// File: rtl/jk_pkg.sv
// Shared types and helpers for the JK bank driver: command opcodes, FSM states
// and the per-bit J/K excitation rule.
package jk_pkg;

   typedef enum logic [1:0] {
      LOAD = 2'b00,
      SET  = 2'b01,
      CLR  = 2'b10,
      TOG  = 2'b11
   } jk_op_e;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      APPLY = 2'b01,
      CHECK = 2'b10
   } state_e;

   // Returns {j,k} that moves one JK bit from current value c to expected value e.
   function automatic logic [1:0] jk_excite(input logic c, input logic e, input logic toggle_dc);
      logic [1:0] jk;
      jk = 2'b00;
      if (c != e) begin
         if (toggle_dc) jk = 2'b11;
         else           jk = e ? 2'b10 : 2'b01;
      end
      return jk;
   endfunction

endpackage

// File: rtl/jk_bank.sv
// Bank of WIDTH independent JK flip-flops with asynchronous active-low clear.
module jk_bank #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] j_i,
   input  logic [WIDTH-1:0] k_i,
   output logic [WIDTH-1:0] q_o
);

   // JK characteristic: 00 hold, 01 reset, 10 set, 11 toggle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) q_o <= '0;
      else        q_o <= (j_i & ~q_o) | (~k_i & q_o);
   end

endmodule

// File: rtl/jk_bank_driver.sv
// Command-driven controller that turns LOAD/SET/CLR/TOG commands into one cycle
// of J/K excitation for a JK bank, then checks the resulting state.
module jk_bank_driver
   import jk_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter bit          TOGGLE_DC = 1'b0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         cmd_valid,
   output logic                         cmd_ready,
   input  logic [1:0]                   cmd_op,
   input  logic [WIDTH-1:0]             cmd_data,
   output logic [WIDTH-1:0]             j_out,
   output logic [WIDTH-1:0]             k_out,
   output logic [WIDTH-1:0]             q,
   output logic                         done,
   output logic [$clog2(WIDTH+1)-1:0]   flips,
   output logic                         err
);

   localparam int unsigned FLIPS_W = $clog2(WIDTH + 1);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   exp_q, exp_d;
   logic [WIDTH-1:0]   qb_q, qb_d;
   logic [WIDTH-1:0]   j_q, j_d;
   logic [WIDTH-1:0]   k_q, k_d;
   logic               ready_q, ready_d;
   logic               done_q, done_d;
   logic [FLIPS_W-1:0] flips_q, flips_d;
   logic               err_q, err_d;

   logic [WIDTH-1:0]   exp_c;
   logic [WIDTH-1:0]   jx_c, kx_c;
   logic [WIDTH-1:0]   diff_c;
   logic [FLIPS_W-1:0] pop_c;

   jk_bank #(.WIDTH(WIDTH)) u_bank (
      .clk   (clk),
      .rst_n (rst),
      .j_i   (j_q),
      .k_i   (k_q),
      .q_o   (q)
   );

   // Target state for the command currently presented
   always_comb begin
      exp_c = cmd_data;
      case (jk_op_e'(cmd_op))
         LOAD:    exp_c = cmd_data;
         SET:     exp_c = q | cmd_data;
         CLR:     exp_c = q & ~cmd_data;
         TOG:     exp_c = q ^ cmd_data;
         default: exp_c = cmd_data;
      endcase
   end

   always_comb begin
      jx_c = '0;
      kx_c = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         {jx_c[i], kx_c[i]} = jk_excite(q[i], exp_c[i], TOGGLE_DC);
      end
   end

   // Number of bits the finished command changed
   always_comb begin
      diff_c = exp_q ^ qb_q;
      pop_c  = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         pop_c = pop_c + FLIPS_W'(diff_c[i]);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      exp_d   = exp_q;
      qb_d    = qb_q;
      j_d     = '0;
      k_d     = '0;
      done_d  = 1'b0;
      flips_d = flips_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               exp_d   = exp_c;
               qb_d    = q;
               j_d     = jx_c;
               k_d     = kx_c;
               state_d = APPLY;
            end
         end
         APPLY: begin
            done_d  = 1'b1;
            flips_d = pop_c;
            state_d = CHECK;
         end
         CHECK: begin
            if (q != exp_q) err_d = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         exp_q   <= '0;
         qb_q    <= '0;
         j_q     <= '0;
         k_q     <= '0;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
         flips_q <= '0;
         err_q   <= 1'b0;
      end else begin
         exp_q   <= exp_d;
         qb_q    <= qb_d;
         j_q     <= j_d;
         k_q     <= k_d;
         ready_q <= ready_d;
         done_q  <= done_d;
         flips_q <= flips_d;
         err_q   <= err_d;
      end
   end

   assign cmd_ready = ready_q;
   assign j_out     = j_q;
   assign k_out     = k_q;
   assign done      = done_q;
   assign flips     = flips_q;
   assign err       = err_q;

endmodule

// File: tb/tb_jk_bank_driver.sv
// Randomized self-checking bench: two driver instances (TOGGLE_DC 0 and 1) share
// stimulus and are compared against a word-level model of the command rules.
module tb_jk_bank_driver;

   localparam int unsigned W  = 8;
   localparam int unsigned FW = $clog2(W + 1);

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid;
   logic [1:0]    cmd_op;
   logic [W-1:0]  cmd_data;

   logic          rdy0, rdy1, done0, done1, err0, err1;
   logic [W-1:0]  j0, k0, q0, j1, k1, q1;
   logic [FW-1:0] fl0, fl1;

   int checks   = 0;
   int failures = 0;

   logic [W-1:0] mq;

   always #5 clk = ~clk;

   jk_bank_driver #(.WIDTH(W), .TOGGLE_DC(1'b0)) dut0 (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(rdy0), .cmd_op(cmd_op),
      .cmd_data(cmd_data), .j_out(j0), .k_out(k0), .q(q0), .done(done0), .flips(fl0), .err(err0)
   );

   jk_bank_driver #(.WIDTH(W), .TOGGLE_DC(1'b1)) dut1 (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(rdy1), .cmd_op(cmd_op),
      .cmd_data(cmd_data), .j_out(j1), .k_out(k1), .q(q1), .done(done1), .flips(fl1), .err(err1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_rdy0"}, 32'(rdy0), 32'd1);
      check({tag, "_rdy1"}, 32'(rdy1), 32'd1);
      check({tag, "_done0"}, 32'(done0), 32'd0);
      check({tag, "_done1"}, 32'(done1), 32'd0);
      check({tag, "_jk0"}, 32'({j0, k0}), 32'd0);
      check({tag, "_jk1"}, 32'({j1, k1}), 32'd0);
      check({tag, "_q0"}, 32'(q0), 32'(mq));
      check({tag, "_q1"}, 32'(q1), 32'(mq));
      check({tag, "_err0"}, 32'(err0), 32'd0);
      check({tag, "_err1"}, 32'(err1), 32'd0);
   endtask

   // Starts at a falling edge in IDLE, ends at the falling edge of the next IDLE cycle.
   task automatic issue(input logic [1:0] op, input logic [W-1:0] data);
      logic [W-1:0] e, d;
      logic [FW-1:0] nf;
      case (op)
         2'd0:    e = data;
         2'd1:    e = mq | data;
         2'd2:    e = mq & ~data;
         default: e = mq ^ data;
      endcase
      d  = mq ^ e;
      nf = FW'($countones(d));
      check("acc_rdy", 32'(rdy0 & rdy1), 32'd1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = data;
      @(negedge clk);
      check("apply_j0", 32'(j0), 32'(e & ~mq));
      check("apply_k0", 32'(k0), 32'(mq & ~e));
      check("apply_j1", 32'(j1), 32'(d));
      check("apply_k1", 32'(k1), 32'(d));
      check("apply_rdy", 32'({rdy0, rdy1}), 32'd0);
      check("apply_done", 32'({done0, done1}), 32'd0);
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_op    = 2'($urandom);
      cmd_data  = W'($urandom);
      @(negedge clk);
      check("chk_done0", 32'(done0), 32'd1);
      check("chk_done1", 32'(done1), 32'd1);
      check("chk_flips0", 32'(fl0), 32'(nf));
      check("chk_flips1", 32'(fl1), 32'(nf));
      check("chk_q0", 32'(q0), 32'(e));
      check("chk_q1", 32'(q1), 32'(e));
      check("chk_jk", 32'({j0, k0, j1, k1}), 32'd0);
      check("chk_rdy", 32'({rdy0, rdy1}), 32'd0);
      cmd_valid = 1'b0;
      mq = e;
      @(negedge clk);
      check_idle_outputs("idle");
      check("idle_flips0", 32'(fl0), 32'(nf));
   endtask

   initial begin
      int ndone;
      int last_done;
      rst       = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = 2'd0;
      cmd_data  = '0;
      mq        = '0;

      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
      check("reset_flips", 32'({fl0, fl1}), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      check_idle_outputs("post_reset");

      // directed sequence from the operating examples
      issue(2'd0, 8'hA5);
      issue(2'd2, 8'h0F);
      issue(2'd3, 8'hFF);
      issue(2'd0, 8'h3C);
      issue(2'd0, 8'hC3);
      issue(2'd1, 8'h00);
      issue(2'd2, 8'h00);
      issue(2'd0, 8'h00);
      issue(2'd1, 8'hFF);
      issue(2'd1, 8'hFF);

      for (int n = 0; n < 40; n++) begin
         issue(2'($urandom), W'($urandom));
      end

      // valid held high: one accept every 3 cycles
      cmd_valid = 1'b1;
      cmd_op    = 2'd3;
      cmd_data  = 8'h11;
      ndone     = 0;
      last_done = -1;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         if (done0) begin
            if (last_done >= 0) check("b2b_spacing", 32'(i - last_done), 32'd3);
            last_done = i;
            ndone++;
         end
      end
      cmd_valid = 1'b0;
      check("b2b_count", 32'(ndone), 32'd4);
      check("b2b_last", 32'(last_done), 32'd11);
      check_idle_outputs("b2b_end");

      // reset while in APPLY
      cmd_valid = 1'b1;
      cmd_op    = 2'd0;
      cmd_data  = ~mq;
      @(negedge clk);
      cmd_valid = 1'b0;
      rst = 1'b0;
      mq  = '0;
      #1;
      check_idle_outputs("rst_apply");
      @(negedge clk);
      check("rst_nodone", 32'({done0, done1}), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      check_idle_outputs("rst_release");
      issue(2'd0, 8'h5A);
      issue(2'd3, 8'h0F);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
